// File: rtl/duck_pkg.sv
// Shared state encoding, default game constants and saturating score helper
// for the duck round sequencer.
package duck_pkg;

    typedef enum logic [2:0] {
        SPAWN,
        ACTIVE,
        FALLING,
        FLEEING,
        TALLY,
        NEXT_ROUND,
        GAME_OVER
    } state_e;

    localparam int DEF_AMMO            = 3;
    localparam int DEF_BIRDS_PER_ROUND = 10;
    localparam int DEF_MIN_HITS        = 6;
    localparam int DEF_ESCAPE_TICKS    = 40;
    localparam int DEF_EXIT_TICKS      = 16;
    localparam int DEF_MAX_ROUND       = 15;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {13'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/duck_round_ctrl_if.sv
// Player/hit-test inputs and movement-FSM status outputs of the round sequencer.
interface duck_round_ctrl_if;

    logic        tick;
    logic        trigger;
    logic        onTarget;
    logic        birdOffscreen;
    logic        isShot;
    logic        escape;
    logic        outOfAmmo;
    logic        leave;
    logic [3:0]  round;
    logic [1:0]  ammo;
    logic [3:0]  hits;
    logic [15:0] score;
    logic        gameOver;

    modport master (
        output tick, trigger, onTarget, birdOffscreen,
        input  isShot, escape, outOfAmmo, leave, round, ammo, hits, score, gameOver
    );

    modport slave (
        input  tick, trigger, onTarget, birdOffscreen,
        output isShot, escape, outOfAmmo, leave, round, ammo, hits, score, gameOver
    );

endinterface

// File: rtl/tick_timer.sv
// Rising-edge detector on the slow animation tick plus an 8-bit loadable
// down-counter that only steps on detected edges.
module tick_timer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec_en,
    output logic       tick_edge,
    output logic       last,
    output logic       zero
);

    logic       tick_q, tick_d;
    logic [7:0] count_q, count_d;

    always_comb begin
        tick_d    = tick;
        tick_edge = tick & ~tick_q;
        count_d   = count_q;
        // A load always wins over a coincident decrement request.
        if (load) begin
            count_d = load_val;
        end else if (dec_en && tick_edge && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q  <= 1'b0;
            count_q <= 8'd0;
        end else begin
            tick_q  <= tick_d;
            count_q <= count_d;
        end
    end

    assign last = (count_q == 8'd1);
    assign zero = (count_q == 8'd0);

endmodule

// File: rtl/duck_round_ctrl.sv
// Game-level sequencer for one duck per bird turn: ammo, escape/exit timing,
// hit accounting, round advance and score driving the movement FSM.
//
// state      | meaning
// SPAWN      | reload ammo, arm escape timer, pulse leave, clear bird flags
// ACTIVE     | bird on screen; shots and escape timer live
// FALLING    | bird hit; wait for offscreen or exit timeout
// FLEEING    | bird escaping; wait for offscreen or exit timeout
// TALLY      | count finished bird; end round after the last one
// NEXT_ROUND | pass/fail decision and round advance
// GAME_OVER  | frozen until a trigger restarts the game
module duck_round_ctrl
    import duck_pkg::*;
#(
    parameter int AMMO            = DEF_AMMO,
    parameter int BIRDS_PER_ROUND = DEF_BIRDS_PER_ROUND,
    parameter int MIN_HITS        = DEF_MIN_HITS,
    parameter int ESCAPE_TICKS    = DEF_ESCAPE_TICKS,
    parameter int EXIT_TICKS      = DEF_EXIT_TICKS,
    parameter int MAX_ROUND       = DEF_MAX_ROUND
) (
    input  logic             clk,
    input  logic             reset_n,
    duck_round_ctrl_if.slave io
);

    localparam logic [1:0] AMMO_L      = 2'(AMMO);
    localparam logic [3:0] LAST_BIRD_L = 4'(BIRDS_PER_ROUND - 1);
    localparam logic [3:0] MIN_HITS_L  = 4'(MIN_HITS);
    localparam logic [3:0] MAX_ROUND_L = 4'(MAX_ROUND);
    localparam logic [7:0] ESCAPE_L    = 8'(ESCAPE_TICKS);
    localparam logic [7:0] EXIT_L      = 8'(EXIT_TICKS);

    state_e      state_q, state_d;
    logic [3:0]  round_q, round_d;
    logic [1:0]  ammo_q, ammo_d;
    logic [3:0]  hits_q, hits_d;
    logic [15:0] score_q, score_d;
    logic [3:0]  bird_cnt_q, bird_cnt_d;
    logic        is_shot_q, is_shot_d;
    logic        escape_q, escape_d;
    logic        out_of_ammo_q, out_of_ammo_d;
    logic        leave_q, leave_d;
    logic        game_over_q, game_over_d;

    logic        tmr_load;
    logic        tmr_dec;
    logic [7:0]  tmr_val;
    logic        tick_edge;
    logic        tmr_last;
    logic        tmr_zero;

    tick_timer u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (io.tick),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .dec_en    (tmr_dec),
        .tick_edge (tick_edge),
        .last      (tmr_last),
        .zero      (tmr_zero)
    );

    always_comb begin
        state_d       = state_q;
        round_d       = round_q;
        ammo_d        = ammo_q;
        hits_d        = hits_q;
        score_d       = score_q;
        bird_cnt_d    = bird_cnt_q;
        is_shot_d     = is_shot_q;
        escape_d      = escape_q;
        out_of_ammo_d = out_of_ammo_q;
        game_over_d   = game_over_q;
        leave_d       = 1'b0;
        tmr_load      = 1'b0;
        tmr_dec       = 1'b0;
        tmr_val       = ESCAPE_L;

        case (state_q)
            SPAWN: begin
                leave_d       = 1'b1;
                is_shot_d     = 1'b0;
                escape_d      = 1'b0;
                out_of_ammo_d = 1'b0;
                ammo_d        = AMMO_L;
                tmr_load      = 1'b1;
                tmr_val       = ESCAPE_L;
                state_d       = ACTIVE;
            end
            ACTIVE: begin
                // A serviced trigger swallows any tick edge in the same cycle.
                if (io.trigger && (ammo_q != 2'd0)) begin
                    ammo_d = ammo_q - 2'd1;
                    if (io.onTarget) begin
                        is_shot_d = 1'b1;
                        hits_d    = hits_q + 4'd1;
                        score_d   = sat_add16(score_q, round_q);
                        tmr_load  = 1'b1;
                        tmr_val   = EXIT_L;
                        state_d   = FALLING;
                    end else if (ammo_q == 2'd1) begin
                        out_of_ammo_d = 1'b1;
                        escape_d      = 1'b1;
                        tmr_load      = 1'b1;
                        tmr_val       = EXIT_L;
                        state_d       = FLEEING;
                    end
                end else if (tick_edge) begin
                    tmr_dec = 1'b1;
                    if (tmr_last) begin
                        escape_d = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = EXIT_L;
                        state_d  = FLEEING;
                    end
                end
            end
            FALLING, FLEEING: begin
                if (io.birdOffscreen || tmr_zero) begin
                    state_d = TALLY;
                end else if (tick_edge) begin
                    tmr_dec = 1'b1;
                    if (tmr_last) begin
                        state_d = TALLY;
                    end
                end
            end
            TALLY: begin
                if (bird_cnt_q == LAST_BIRD_L) begin
                    bird_cnt_d = 4'd0;
                    state_d    = NEXT_ROUND;
                end else begin
                    bird_cnt_d = bird_cnt_q + 4'd1;
                    state_d    = SPAWN;
                end
            end
            NEXT_ROUND: begin
                if ((hits_q < MIN_HITS_L) || (round_q == MAX_ROUND_L)) begin
                    game_over_d = 1'b1;
                    state_d     = GAME_OVER;
                end else begin
                    round_d = round_q + 4'd1;
                    hits_d  = 4'd0;
                    state_d = SPAWN;
                end
            end
            GAME_OVER: begin
                if (io.trigger) begin
                    round_d     = 4'd1;
                    score_d     = 16'd0;
                    hits_d      = 4'd0;
                    bird_cnt_d  = 4'd0;
                    game_over_d = 1'b0;
                    state_d     = SPAWN;
                end
            end
            default: state_d = SPAWN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= SPAWN;
            round_q       <= 4'd1;
            ammo_q        <= AMMO_L;
            hits_q        <= 4'd0;
            score_q       <= 16'd0;
            bird_cnt_q    <= 4'd0;
            is_shot_q     <= 1'b0;
            escape_q      <= 1'b0;
            out_of_ammo_q <= 1'b0;
            leave_q       <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            round_q       <= round_d;
            ammo_q        <= ammo_d;
            hits_q        <= hits_d;
            score_q       <= score_d;
            bird_cnt_q    <= bird_cnt_d;
            is_shot_q     <= is_shot_d;
            escape_q      <= escape_d;
            out_of_ammo_q <= out_of_ammo_d;
            leave_q       <= leave_d;
            game_over_q   <= game_over_d;
        end
    end

    assign io.isShot    = is_shot_q;
    assign io.escape    = escape_q;
    assign io.outOfAmmo = out_of_ammo_q;
    assign io.leave     = leave_q;
    assign io.round     = round_q;
    assign io.ammo      = ammo_q;
    assign io.hits      = hits_q;
    assign io.score     = score_q;
    assign io.gameOver  = game_over_q;

endmodule

// File: tb/tb_duck_round_ctrl.sv
// Scenario bench for duck_round_ctrl against a bird-level game model.
module tb_duck_round_ctrl;

    localparam int AMMO      = 3;
    localparam int BPR       = 10;
    localparam int MIN_HITS  = 6;
    localparam int ESC       = 40;
    localparam int EXIT      = 16;
    localparam int MAX_ROUND = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    int   leave_cnt = 0;

    int   m_round, m_hits, m_score, m_birds;
    bit   m_over;

    duck_round_ctrl_if dif ();

    duck_round_ctrl #(
        .AMMO(AMMO), .BIRDS_PER_ROUND(BPR), .MIN_HITS(MIN_HITS),
        .ESCAPE_TICKS(ESC), .EXIT_TICKS(EXIT), .MAX_ROUND(MAX_ROUND)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (dif.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dif.leave === 1'b1) leave_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- bird-level game model ----------------
    task automatic model_reset();
        m_round = 1; m_hits = 0; m_score = 0; m_birds = 0; m_over = 0;
    endtask

    task automatic model_hit();
        m_hits++;
        m_score = (m_score + m_round > 65535) ? 65535 : m_score + m_round;
    endtask

    task automatic model_bird_end();
        m_birds++;
        if (m_birds == BPR) begin
            m_birds = 0;
            if (m_hits < MIN_HITS || m_round == MAX_ROUND) m_over = 1;
            else begin m_round++; m_hits = 0; end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input bit tr, input bit ot, input bit off, input bit tk);
        dif.trigger = tr; dif.onTarget = ot; dif.birdOffscreen = off; dif.tick = tk;
        @(posedge clk); #1;
        dif.trigger = 0; dif.onTarget = 0; dif.birdOffscreen = 0; dif.tick = 0;
    endtask

    task automatic tick_edges(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 0, 1);
            cyc(0, 0, 0, 0);
        end
    endtask

    task automatic wait_next();
        for (int i = 0; i < 12; i++) begin
            if (dif.leave === 1'b1 || dif.gameOver === 1'b1) break;
            cyc(0, 0, 0, 0);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        dif.trigger = 0; dif.onTarget = 0; dif.birdOffscreen = 0; dif.tick = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    // One bird: `misses` missed shots, then a hit if `hit`.
    task automatic play_bird(input bit hit, input int misses);
        logic [1:0] exp_ammo;
        bit         shot, exp_out;
        int         nshots;
        nshots = misses + (hit ? 1 : 0);
        for (int s = 0; s < nshots; s++) begin
            tick_edges($urandom_range(0, 2));
            shot = hit && (s == misses);
            cyc(1, shot, 0, 0);
            if (shot) model_hit();
            exp_ammo = 2'(AMMO - 1 - s);
            exp_out  = !hit && (s == AMMO - 1);
            n_total++;
            if (dif.ammo !== exp_ammo) $display("FAIL bird_ammo: got %0d expected %0d", dif.ammo, exp_ammo);
            else n_pass++;
            n_total++;
            if (dif.isShot !== shot) $display("FAIL bird_isShot: got %0b expected %0b", dif.isShot, shot);
            else n_pass++;
            n_total++;
            if ({dif.outOfAmmo, dif.escape} !== {exp_out, exp_out})
                $display("FAIL bird_outOfAmmo_escape: got %b expected %b", {dif.outOfAmmo, dif.escape}, {exp_out, exp_out});
            else n_pass++;
        end
        n_total++;
        if (dif.score !== 16'(m_score)) $display("FAIL bird_score: got %0d expected %0d", dif.score, m_score);
        else n_pass++;
        cyc(0, 0, 1, 0);
        model_bird_end();
        wait_next();
        n_total++;
        if (m_over) begin
            if ({dif.gameOver, dif.round, dif.hits} !== {1'b1, 4'(m_round), 4'(m_hits)})
                $display("FAIL bird_end_over: got go=%0b round=%0d hits=%0d expected go=1 round=%0d hits=%0d",
                         dif.gameOver, dif.round, dif.hits, m_round, m_hits);
            else n_pass++;
        end else begin
            if ({dif.leave, dif.isShot, dif.escape, dif.outOfAmmo, dif.ammo, dif.round, dif.hits}
                !== {4'b1000, 2'(AMMO), 4'(m_round), 4'(m_hits)})
                $display("FAIL bird_end_next: got leave=%0b flags=%b ammo=%0d round=%0d hits=%0d expected round=%0d hits=%0d",
                         dif.leave, {dif.isShot, dif.escape, dif.outOfAmmo}, dif.ammo, dif.round, dif.hits, m_round, m_hits);
            else n_pass++;
        end
    endtask

    task automatic play_round(input int target);
        int need;
        bit h;
        need = target;
        for (int b = 0; b < BPR; b++) begin
            if (need == BPR - b) h = 1;
            else if (need == 0) h = 0;
            else h = 1'($urandom_range(0, 1));
            if (h) need--;
            play_bird(h, h ? $urandom_range(0, AMMO - 1) : AMMO);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int base;
        reset_n = 1'b0;
        dif.trigger = 0; dif.onTarget = 0; dif.birdOffscreen = 0; dif.tick = 0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (dif.round !== 4'd1) $display("FAIL reset_round: got %0d expected 1", dif.round); else n_pass++;
        n_total++;
        if (dif.ammo !== 2'(AMMO)) $display("FAIL reset_ammo: got %0d expected %0d", dif.ammo, AMMO); else n_pass++;
        n_total++;
        if ({dif.hits, dif.score} !== 20'd0) $display("FAIL reset_hits_score: got %0d/%0d expected 0/0", dif.hits, dif.score); else n_pass++;
        n_total++;
        if ({dif.isShot, dif.escape, dif.outOfAmmo, dif.leave, dif.gameOver} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {dif.isShot, dif.escape, dif.outOfAmmo, dif.leave, dif.gameOver});
        else n_pass++;
        reset_n = 1'b1;
        model_reset();
        base = leave_cnt;
        wait_next();
        n_total++;
        if (dif.leave !== 1'b1) $display("FAIL first_leave: got %0b expected 1", dif.leave); else n_pass++;
        cyc(0, 0, 0, 0);
        n_total++;
        if (dif.leave !== 1'b0 || leave_cnt != base + 1)
            $display("FAIL leave_one_cycle: got leave=%0b pulses=%0d expected 0/1", dif.leave, leave_cnt - base);
        else n_pass++;
    endtask

    task automatic test_hit();
        cyc(1, 1, 0, 0);
        model_hit();
        n_total++;
        if ({dif.isShot, dif.ammo, dif.hits, dif.score} !== {1'b1, 2'(AMMO - 1), 4'(m_hits), 16'(m_score)})
            $display("FAIL hit: got shot=%0b ammo=%0d hits=%0d score=%0d expected 1/%0d/%0d/%0d",
                     dif.isShot, dif.ammo, dif.hits, dif.score, AMMO - 1, m_hits, m_score);
        else n_pass++;
        cyc(1, 1, 0, 0);
        n_total++;
        if ({dif.ammo, dif.hits} !== {2'(AMMO - 1), 4'(m_hits)})
            $display("FAIL falling_trigger_ignored: got ammo=%0d hits=%0d expected %0d/%0d", dif.ammo, dif.hits, AMMO - 1, m_hits);
        else n_pass++;
        cyc(0, 0, 1, 0);
        model_bird_end();
        wait_next();
        n_total++;
        if ({dif.leave, dif.isShot, dif.ammo} !== {1'b1, 1'b0, 2'(AMMO)})
            $display("FAIL hit_respawn: got leave=%0b shot=%0b ammo=%0d expected 1/0/%0d", dif.leave, dif.isShot, dif.ammo, AMMO);
        else n_pass++;
    endtask

    task automatic test_miss_out();
        bit last;
        for (int s = 0; s < AMMO; s++) begin
            cyc(1, 0, 0, 0);
            last = (s == AMMO - 1);
            n_total++;
            if ({dif.ammo, dif.outOfAmmo, dif.escape} !== {2'(AMMO - 1 - s), last, last})
                $display("FAIL miss_shot%0d: got ammo=%0d oa=%0b esc=%0b expected %0d/%0b/%0b",
                         s, dif.ammo, dif.outOfAmmo, dif.escape, AMMO - 1 - s, last, last);
            else n_pass++;
        end
        cyc(1, 0, 0, 0);
        n_total++;
        if (dif.ammo !== 2'd0) $display("FAIL fleeing_ammo_frozen: got %0d expected 0", dif.ammo); else n_pass++;
        cyc(0, 0, 1, 0);
        model_bird_end();
        wait_next();
        n_total++;
        if ({dif.leave, dif.isShot, dif.escape, dif.outOfAmmo, dif.ammo} !== {4'b1000, 2'(AMMO)})
            $display("FAIL miss_respawn: got leave=%0b flags=%b ammo=%0d", dif.leave, {dif.isShot, dif.escape, dif.outOfAmmo}, dif.ammo);
        else n_pass++;
    endtask

    task automatic test_escape();
        int base;
        tick_edges(ESC - 1);
        n_total++;
        if (dif.escape !== 1'b0) $display("FAIL escape_early: got %0b expected 0", dif.escape); else n_pass++;
        cyc(0, 0, 0, 1);
        n_total++;
        if ({dif.escape, dif.outOfAmmo} !== 2'b10) $display("FAIL escape_on_edge: got %b expected 10", {dif.escape, dif.outOfAmmo}); else n_pass++;
        cyc(0, 0, 0, 0);
        base = leave_cnt;
        tick_edges(EXIT - 1);
        n_total++;
        if (dif.escape !== 1'b1 || leave_cnt != base)
            $display("FAIL exit_early: got esc=%0b leaves=%0d expected 1/0", dif.escape, leave_cnt - base);
        else n_pass++;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        n_total++;
        if (dif.leave !== 1'b0) $display("FAIL exit_spawn_timing: got leave=%0b expected 0", dif.leave); else n_pass++;
        cyc(0, 0, 0, 0);
        model_bird_end();
        n_total++;
        if ({dif.leave, dif.escape, dif.hits} !== {2'b10, 4'(m_hits)})
            $display("FAIL exit_timeout_respawn: got leave=%0b esc=%0b hits=%0d expected 1/0/%0d", dif.leave, dif.escape, dif.hits, m_hits);
        else n_pass++;
    endtask

    task automatic test_trig_tick();
        int base;
        tick_edges(ESC - 1);
        cyc(1, 0, 0, 1);
        n_total++;
        if ({dif.ammo, dif.escape} !== {2'(AMMO - 1), 1'b0})
            $display("FAIL trig_tick_miss: got ammo=%0d esc=%0b expected %0d/0", dif.ammo, dif.escape, AMMO - 1);
        else n_pass++;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        n_total++;
        if (dif.escape !== 1'b1) $display("FAIL tick_after_dropped: got esc=%0b expected 1", dif.escape); else n_pass++;
        cyc(0, 0, 1, 0);
        model_bird_end();
        wait_next();
        cyc(1, 1, 0, 1);
        model_hit();
        n_total++;
        if ({dif.isShot, dif.escape, dif.hits, dif.score} !== {2'b10, 4'(m_hits), 16'(m_score)})
            $display("FAIL trig_tick_hit: got shot=%0b esc=%0b hits=%0d score=%0d expected 1/0/%0d/%0d",
                     dif.isShot, dif.escape, dif.hits, dif.score, m_hits, m_score);
        else n_pass++;
        cyc(0, 0, 0, 0);
        base = leave_cnt;
        tick_edges(EXIT - 1);
        n_total++;
        if (leave_cnt != base) $display("FAIL exit_timer_full: got %0d early spawns expected 0", leave_cnt - base); else n_pass++;
        cyc(0, 0, 0, 1);
        model_bird_end();
        wait_next();
        n_total++;
        if (dif.leave !== 1'b1) $display("FAIL fall_timeout_respawn: got leave=%0b expected 1", dif.leave); else n_pass++;
    endtask

    task automatic test_last_shot();
        play_bird(1, AMMO - 1);
        play_bird(0, AMMO);
    endtask

    task automatic test_rounds();
        do_reset();
        wait_next();
        play_round($urandom_range(MIN_HITS, BPR));
        n_total++;
        if ({dif.round, dif.hits, dif.gameOver} !== {4'd2, 4'd0, 1'b0})
            $display("FAIL round_pass: got round=%0d hits=%0d go=%0b expected 2/0/0", dif.round, dif.hits, dif.gameOver);
        else n_pass++;
        play_round(MIN_HITS - 1);
        n_total++;
        if ({dif.gameOver, dif.round} !== {1'b1, 4'd2})
            $display("FAIL round_fail: got go=%0b round=%0d expected 1/2", dif.gameOver, dif.round);
        else n_pass++;
        cyc(1, 0, 0, 0);
        model_reset();
        wait_next();
        n_total++;
        if ({dif.leave, dif.gameOver, dif.round, dif.score, dif.hits} !== {2'b10, 4'd1, 16'd0, 4'd0})
            $display("FAIL restart: got leave=%0b go=%0b round=%0d score=%0d hits=%0d expected 1/0/1/0/0",
                     dif.leave, dif.gameOver, dif.round, dif.score, dif.hits);
        else n_pass++;
    endtask

    task automatic test_max_round();
        do_reset();
        wait_next();
        for (int r = 1; r <= MAX_ROUND; r++) play_round($urandom_range(MIN_HITS, BPR));
        n_total++;
        if ({dif.gameOver, dif.round, dif.score} !== {1'b1, 4'(MAX_ROUND), 16'(m_score)})
            $display("FAIL max_round: got go=%0b round=%0d score=%0d expected 1/%0d/%0d",
                     dif.gameOver, dif.round, dif.score, MAX_ROUND, m_score);
        else n_pass++;
        cyc(1, 0, 0, 0);
        model_reset();
        wait_next();
        cyc(1, 1, 0, 0);
        n_total++;
        if ({dif.isShot, dif.score} !== {1'b1, 16'd1})
            $display("FAIL pre_reset_hit: got shot=%0b score=%0d expected 1/1", dif.isShot, dif.score);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if ({dif.isShot, dif.escape, dif.outOfAmmo, dif.leave, dif.gameOver, dif.round, dif.ammo, dif.hits, dif.score}
            !== {5'b0, 4'd1, 2'(AMMO), 4'd0, 16'd0})
            $display("FAIL async_reset: got flags=%b round=%0d ammo=%0d hits=%0d score=%0d",
                     {dif.isShot, dif.escape, dif.outOfAmmo, dif.leave, dif.gameOver}, dif.round, dif.ammo, dif.hits, dif.score);
        else n_pass++;
    endtask

    initial begin
        dif.trigger = 0; dif.onTarget = 0; dif.birdOffscreen = 0; dif.tick = 0;
        test_reset();
        test_hit();
        test_miss_out();
        test_escape();
        test_trig_tick();
        test_last_shot();
        test_rounds();
        test_max_round();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
